// File: rtl/sigmoid_share_pkg.sv
// Shared constants and types for the shared sigmoid pipeline arbiter.
package sigmoid_share_pkg;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_HALF = 16'h3800;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  localparam int SIGMOID_LAT_A10 = 5;
  localparam int SIGMOID_LAT_S10 = 8;

  // The entry ID field is wide enough for the largest supported requester count (16).
  localparam int RSP_ID_W = 4;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [15:0]         data;
  } rsp_entry_t;
endpackage

// File: rtl/sigmoid_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is always presented from flops, and occupancy is reported.
module sigmoid_rsp_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             areset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] occ
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop = pop && valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is reset so the outputs read as zero after reset.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (occ != '0);
endmodule

// File: rtl/sigmoid_share_arb.sv
// Round-robin sharing of one fixed-latency FP16 sigmoid core, with ID tracking and a credit-guarded response FIFO.
module sigmoid_share_arb
  import sigmoid_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = SIGMOID_LAT_A10,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [15:0]           core_a,
  input  logic [15:0]           core_q,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [NUM_REQ-1:0][15:0]  lane_data;
  logic [ID_W-1:0]           ptr, gnt_id, cand;
  logic                      gnt_vld, can_issue, issue, push, pop;
  logic [CNT_W-1:0]          inflight, occ;
  logic [LATENCY:0]          vld_pipe;
  logic [LATENCY:0][ID_W-1:0] id_pipe;
  rsp_entry_t                push_ent, head;
  logic                      unused_id_bits;

  assign lane_data = req_data;

  // A same-cycle pop is not credited, so the FIFO can never overflow.
  assign can_issue = ({1'b0, occ} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      cand = ID_W'((int'(ptr) + o) % NUM_REQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign issue = can_issue && gnt_vld;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  // vld_pipe[0] lines up with core_a; vld_pipe[LATENCY] lines up with core_q.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      ptr      <= ID_W'(NUM_REQ-1);
      core_a   <= FP16_ZERO;
      vld_pipe <= '0;
      id_pipe  <= '0;
      inflight <= '0;
    end else begin
      if (issue) ptr <= gnt_id;
      core_a   <= issue ? lane_data[gnt_id] : FP16_ZERO;
      vld_pipe <= {vld_pipe[LATENCY-1:0], issue};
      id_pipe  <= {id_pipe[LATENCY-1:0], gnt_id};
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push          = vld_pipe[LATENCY];
  assign push_ent.id   = RSP_ID_W'(id_pipe[LATENCY]);
  assign push_ent.data = core_q;
  assign pop           = rsp_valid && rsp_ready;

  sigmoid_rsp_fifo #(
    .W     ($bits(rsp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .areset (areset),
    .push   (push),
    .din    (push_ent),
    .pop    (pop),
    .dout   (head),
    .valid  (rsp_valid),
    .occ    (occ)
  );

  assign rsp_id         = head.id[ID_W-1:0];
  assign rsp_data       = head.data;
  assign unused_id_bits = ^head.id;
  assign busy           = (inflight != '0) || (occ != '0);
endmodule

// File: tb/tb_sigmoid_share_arb.sv
// Scoreboard bench: behavioural LATENCY-cycle sigmoid core, issue-side expectation queue, response-side compare.
module tb_sigmoid_share_arb;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 5;
  localparam int DEPTH   = 8;
  localparam int ID_W    = 2;

  logic                  clock = 1'b0;
  logic                  areset;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [NUM_REQ*16-1:0] req_data;
  logic [15:0]           core_a, core_q, rsp_data;
  logic                  rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]       rsp_id;

  always #5 clock = ~clock;

  sigmoid_share_arb #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .core_a(core_a), .core_q(core_q), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic [15:0] fp16_sigmoid(input logic [15:0] x);
    real v, s, m;
    int  ex, e, mi;
    ex = int'(x[14:10]);
    if (ex == 31)     v = 65504.0;
    else if (ex == 0) v = real'(int'(x[9:0])) / 1024.0 * pow2(-14);
    else              v = (1.0 + real'(int'(x[9:0])) / 1024.0) * pow2(ex - 15);
    if (x[15]) v = -v;
    s = 1.0 / (1.0 + $exp(-v));
    if (s >= 1.0) return 16'h3C00;
    if (s < pow2(-14)) return 16'h0000;
    e = -1;
    while (s < pow2(e)) e--;
    m  = s / pow2(e) - 1.0;
    mi = $rtoi(m * 1024.0 + 0.5);
    if (mi >= 1024) begin mi = 0; e++; end
    return {1'b0, 5'(e + 15), 10'(mi)};
  endfunction

  // Behavioural core: result for the operand on core_a appears LAT cycles later.
  logic [15:0] q_pipe [LAT];
  always @(posedge clock) begin
    q_pipe[0] <= fp16_sigmoid(core_a);
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign core_q = q_pipe[LAT-1];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [ID_W-1:0] id; logic [15:0] d; } exp_t;
  exp_t sbq[$];
  int   acc_cnt = 0;
  logic held = 1'b0;
  logic [ID_W-1:0] hold_id;
  logic [15:0]     hold_data;
  exp_t e;

  always @(negedge clock) begin
    if (areset) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_vld", rsp_valid, 1);
        chk("hold_id", rsp_id, hold_id);
        chk("hold_data", rsp_data, hold_data);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back('{ID_W'(i), fp16_sigmoid(req_data[16*i +: 16])});
          acc_cnt++;
        end
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_id", rsp_id, e.id);
          chk("sb_data", rsp_data, e.d);
        end
      end
      held      = rsp_valid && !rsp_ready;
      hold_id   = rsp_id;
      hold_data = rsp_data;
    end
  end

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin @(posedge clock); #1; n++; end
    chk("drain_busy", busy, 0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin @(posedge clock); #1; n++; end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, g, base, stale;
    int pr_exp [6] = '{3, 1, 3, 1, 2, 3};
    areset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    areset = 1'b0;

    // single request, latency
    @(posedge clock); #1;
    req_valid = 4'b0001; req_data = '0;
    @(negedge clock); chk("t1_ready", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    chk("t1_busy", busy, 1);
    wait_rsp(n);
    chk("t1_lat", n, LAT + 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_data", rsp_data, 16'h3800);
    @(posedge clock); #1;
    chk("t1_busy_idle", busy, 0);
    chk("t1_vld_idle", rsp_valid, 0);

    // round robin with all requesters valid
    req_data  = {16'h4400, 16'h3C00, 16'hBC00, 16'h3000};
    req_valid = 4'hF;
    g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      g = (g + 1) % NUM_REQ;
      chk("rr_gnt", req_ready, 32'(1 << g));
    end
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    // credit backpressure
    rsp_ready = 1'b0;
    base = acc_cnt;
    req_valid = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      req_data[15:0] = 16'h3000 + 16'(acc_cnt);
    end
    chk("bp_acc8", acc_cnt - base, 8);
    @(negedge clock); chk("bp_ready0", req_ready, 0);
    @(posedge clock); #1; rsp_ready = 1'b1;
    @(posedge clock); #1; rsp_ready = 1'b0;
    repeat (20) @(posedge clock); #1;
    chk("bp_acc9", acc_cnt - base, 9);
    req_valid = '0; rsp_ready = 1'b1;
    drain();

    // pointer at 1, requesters 1 and 3, then 2 joins
    req_valid = 4'b0010;
    @(negedge clock); chk("pr_setup", req_ready, 4'b0010);
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4) ? 4'b1010 : 4'b1110;
      @(negedge clock); chk("pr_gnt", req_ready, 32'(1 << pr_exp[i]));
      @(posedge clock); #1;
    end
    req_valid = '0;
    drain();

    // reset with 3 in flight and 2 queued
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (5) @(posedge clock); #1;
    req_valid = '0;
    repeat (3) @(posedge clock); #1;
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_vld", rsp_valid, 1);
    #2 areset = 1'b1;
    #1;
    chk("mrst_ready", req_ready, 0);
    chk("mrst_core_a", core_a, 0);
    chk("mrst_vld", rsp_valid, 0);
    chk("mrst_id", rsp_id, 0);
    chk("mrst_data", rsp_data, 0);
    chk("mrst_busy", busy, 0);
    sbq.delete();
    repeat (2) @(posedge clock); #1;
    areset = 1'b0; rsp_ready = 1'b1;
    stale = 0;
    repeat (15) begin @(negedge clock); if (rsp_valid) stale++; end
    chk("mrst_stale", stale, 0);

    // large input from requester 2
    @(posedge clock); #1;
    req_data[47:32] = 16'h4A00;
    req_valid = 4'b0100;
    @(negedge clock); chk("lg_ready", req_ready, 4'b0100);
    @(posedge clock); #1;
    req_valid = '0;
    chk("lg_core_a", core_a, 16'h4A00);
    @(posedge clock); #1;
    chk("lg_core_a_idle", core_a, 0);
    wait_rsp(n);
    chk("lg_id", rsp_id, 2);
    chk("lg_data", rsp_data, 16'h3C00);
    drain();

    chk("sb_left", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sigmoid_share_arb.md
Name: sigmoid_share_arb

Overview:
Shares one fixed-latency FP16 sigmoid pipeline among NUM_REQ requesters. The pipeline has no valid or backpressure. The block round-robin arbitrates valid/ready requests and issues at most one operand per cycle into the core. It tracks each issued operand's requester ID through a latency-matched shift register and captures results into a credit-guarded response FIFO, tagged with the ID. It sits between the RNN activation requesters and the sigmoid core, which is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LATENCY, 5, core latency in clocks (5 for A10, 8 for S10)
FIFO_DEPTH, 8, response FIFO entries; must be >= LATENCY+2 for full throughput, and >= 1
ID_W, $clog2(NUM_REQ), derived requester-ID width

Ports:
clock  in  1  single clock, rising edge
areset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_data  in  NUM_REQ*16  FP16 operands; requester i uses bits [16i+15:16i]
core_a  out  16  registered operand to the sigmoid core
core_q  in  16  sigmoid core result
rsp_valid  out  1  response FIFO head valid
rsp_ready  in  1  consumer accepts head
rsp_id  out  ID_W  requester ID of head result
rsp_data  out  16  FP16 result at head
busy  out  1  high while any operation is in flight or the FIFO is non-empty

Behaviour:
- Reset (asynchronous, active-high, applies immediately):
  - req_ready=0, core_a=16'h0000, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Valid shift register cleared, FIFO emptied, inflight=0, RR pointer=NUM_REQ-1 (so requester 0 has priority first).
  - Assertion mid-operation discards all in-flight and queued results. No stale rsp_valid appears after release.
- Credit: can_issue = (occupancy + inflight) < FIFO_DEPTH. This is deliberately conservative: a same-cycle pop is not credited. As a result the FIFO can never overflow and no push is ever dropped.
- Arbitration (combinational):
  - When can_issue, grant the first req_valid found by searching from (ptr+1) mod NUM_REQ upward, wrapping.
  - req_ready[g]=1 for the granted requester only. req_ready is independent of its own req_valid except through the grant.
  - If no request is valid, or can_issue=0, req_ready is all zero.
- Issue, at edge k where req_valid[g] && req_ready[g]:
  - core_a <= req_data[g]; ptr <= g.
  - Valid shift register stage 0 <= 1 and ID stage 0 <= g.
  - With no issue: core_a <= 16'h0000 and stage 0 valid <= 0; ptr holds.
- Alignment: the shift register is LATENCY stages deep after the core_a register. core_q is the result for the operand accepted at edge k during cycle k+1+LATENCY. It is pushed into the FIFO at edge k+1+LATENCY, together with the ID from the last stage.
- Response: show-ahead FIFO with registered outputs. rsp_valid rises in cycle k+2+LATENCY at the earliest, so minimum accept-to-response latency is LATENCY+2 clocks.
  - rsp_id, rsp_data stable while rsp_valid && !rsp_ready.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle leave occupancy unchanged. Push into an empty FIFO with a same-cycle pop attempt cannot occur, because rsp_valid=0 when empty.
- inflight counter: +1 on issue, -1 on FIFO push, unchanged on both. Width $clog2(FIFO_DEPTH+1).
- Ordering: responses leave in global issue order. Results never reorder.
- busy = (inflight != 0) || (occupancy != 0).

Decomposition:
- Package sigmoid_share_pkg holds:
  - FP16 constants FP16_ZERO=16'h0000, FP16_HALF=16'h3800, FP16_ONE=16'h3C00.
  - A typedef for the {id, data} FIFO entry.
  - The default LATENCY constants: SIGMOID_LAT_A10=5, SIGMOID_LAT_S10=8.
- One sub-module: sigmoid_rsp_fifo, a parameterized show-ahead FIFO that reports occupancy.
- The arbiter and the shift register stay inline.

Test Plan:
The bench pairs the block with a LATENCY-cycle behavioural sigmoid model.
- Single request: req0 only, data 16'h0000 accepted at edge k, rsp_ready=1 -> rsp_valid=1 in cycle k+7 (LATENCY=5), rsp_id=0, rsp_data=16'h3800; busy returns to 0 one cycle later.
- All four req_valid held high, rsp_ready=1 -> grants cycle 0,1,2,3,0,1,... one per clock, no bubble; rsp_id sequence identical to the grant sequence.
- rsp_ready=0, req0 held valid, FIFO_DEPTH=8 -> exactly 8 accepts, then req_ready=0. One rsp_ready pulse -> exactly one further accept; no data lost.
- Requesters 1 and 3 valid, ptr at 1 -> grant order 3,1,3,1; a newly valid requester 2 is served before 3 is served again.
- areset asserted with 3 operations in flight and 2 queued -> all outputs 0 within the same cycle; after release, no rsp_valid until a new request is accepted.
- Large input 16'h4A00 (12.0) from req2 -> rsp_data=16'h3C00, rsp_id=2. core_a returns to 16'h0000 on the next idle cycle.
